// File: rtl/seq_monitor_if.sv
// Sample/result bundle between an upstream driver and seq_monitor.
interface seq_monitor_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             q;
  logic             rise;
  logic             fall;
  logic             hit;
  logic [CNT_W-1:0] hit_cnt;
  logic [3:0]       run_len;

  modport master (output en, q, input rise, fall, hit, hit_cnt, run_len);
  modport slave  (input en, q, output rise, fall, hit, hit_cnt, run_len);
endinterface

// File: rtl/seq_monitor.sv
// Serial bit monitor: edge pulses, overlapping 4-bit pattern hits, hit count and run length of ones.
//
// state | meaning
// EMPTY | no samples since reset
// FILL1 | one sample in history
// FILL2 | two samples in history
// FILL3 | three samples in history
// FULL  | history holds four real samples, pattern match allowed
module seq_monitor #(
  parameter logic [3:0] PATTERN = 4'b1101,
  parameter int         CNT_W   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_monitor_if.slave  bus
);

  typedef enum logic [2:0] {
    EMPTY = 3'd0,
    FILL1 = 3'd1,
    FILL2 = 3'd2,
    FILL3 = 3'd3,
    FULL  = 3'd4
  } fill_e;

  fill_e            fill_q, fill_d;
  logic [3:0]       hist_q, hist_d;
  logic             prev_q, prev_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             hit_q, hit_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [3:0]       run_len_q, run_len_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q    <= EMPTY;
      hist_q    <= 4'b0000;
      prev_q    <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      hit_q     <= 1'b0;
      hit_cnt_q <= '0;
      run_len_q <= 4'd0;
    end else begin
      fill_q    <= fill_d;
      hist_q    <= hist_d;
      prev_q    <= prev_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      hit_q     <= hit_d;
      hit_cnt_q <= hit_cnt_d;
      run_len_q <= run_len_d;
    end
  end

  always_comb begin
    fill_d    = fill_q;
    hist_d    = hist_q;
    prev_d    = prev_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    hit_d     = 1'b0;
    hit_cnt_d = hit_cnt_q;
    run_len_d = run_len_q;

    if (bus.en) begin
      case (fill_q)
        EMPTY:   fill_d = FILL1;
        FILL1:   fill_d = FILL2;
        FILL2:   fill_d = FILL3;
        default: fill_d = FULL;
      endcase
      hist_d = {hist_q[2:0], bus.q};
      prev_d = bus.q;
      rise_d = bus.q & ~prev_q;
      fall_d = ~bus.q & prev_q;
      // fill_d, not fill_q: the fourth sample itself may complete a match
      hit_d  = (hist_d == PATTERN) && (fill_d == FULL);
      if (hit_d) hit_cnt_d = hit_cnt_q + 1'b1;
      if (!bus.q)                run_len_d = 4'd0;
      else if (run_len_q != 4'd15) run_len_d = run_len_q + 4'd1;
    end
  end

  assign bus.rise    = rise_q;
  assign bus.fall    = fall_q;
  assign bus.hit     = hit_q;
  assign bus.hit_cnt = hit_cnt_q;
  assign bus.run_len = run_len_q;

endmodule

// File: tb/tb_seq_monitor.sv
// Directed bench for seq_monitor: an 8-bit and a 2-bit counter instance share stimulus.
module tb_seq_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0;
  logic q = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  seq_monitor_if #(.CNT_W(8)) bus_a ();
  seq_monitor_if #(.CNT_W(2)) bus_b ();

  assign bus_a.en = en;
  assign bus_a.q  = q;
  assign bus_b.en = en;
  assign bus_b.q  = q;

  seq_monitor #(.PATTERN(4'b1101), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  seq_monitor #(.PATTERN(4'b1101), .CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  task automatic chk(input string tag, input int got, input int exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " rise"},    int'(bus_a.rise),    0);
    chk({tag, " fall"},    int'(bus_a.fall),    0);
    chk({tag, " hit"},     int'(bus_a.hit),     0);
    chk({tag, " hit_cnt"}, int'(bus_a.hit_cnt), 0);
    chk({tag, " run_len"}, int'(bus_a.run_len), 0);
    chk({tag, " b_hit"},   int'(bus_b.hit),     0);
    chk({tag, " b_cnt"},   int'(bus_b.hit_cnt), 0);
  endtask

  // reset asserted between edges, held across two edges with live input, released on negedge
  task automatic do_reset(input string tag);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero({tag, " async"});
    en = 1'b1;
    q  = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1 chk_zero({tag, " held"});
    end
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic step(input string tag, input logic e, input logic qv,
                      input int r, input int f, input int h, input int cnt, input int run);
    @(negedge clk);
    en = e;
    q  = qv;
    @(posedge clk);
    #1;
    // q moves after the edge; must not matter until the next sampling edge
    q = ~qv;
    chk({tag, " rise"},    int'(bus_a.rise),    r);
    chk({tag, " fall"},    int'(bus_a.fall),    f);
    chk({tag, " hit"},     int'(bus_a.hit),     h);
    chk({tag, " hit_cnt"}, int'(bus_a.hit_cnt), cnt % 256);
    chk({tag, " run_len"}, int'(bus_a.run_len), run);
    chk({tag, " b_cnt"},   int'(bus_b.hit_cnt), cnt % 4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset("init");

    // basic pattern then overlapping second hit
    step("p1", 1, 1, 1, 0, 0, 0, 1);
    step("p2", 1, 1, 0, 0, 0, 0, 2);
    step("p3", 1, 0, 0, 1, 0, 0, 0);
    step("p4", 1, 1, 1, 0, 1, 1, 1);
    step("p5", 1, 1, 0, 0, 0, 1, 2);
    step("p6", 1, 0, 0, 1, 0, 1, 0);
    step("p7", 1, 1, 1, 0, 1, 2, 1);

    // too few samples, then one hit after five samples
    do_reset("r2");
    step("s1", 1, 1, 1, 0, 0, 0, 1);
    step("s2", 1, 0, 0, 1, 0, 0, 0);
    step("s3", 1, 1, 1, 0, 0, 0, 1);
    step("s4", 1, 1, 0, 0, 0, 0, 2);
    do_reset("r3");
    step("t1", 1, 0, 0, 0, 0, 0, 0);
    step("t2", 1, 1, 1, 0, 0, 0, 1);
    step("t3", 1, 1, 0, 0, 0, 0, 2);
    step("t4", 1, 0, 0, 1, 0, 0, 0);
    step("t5", 1, 1, 1, 0, 1, 1, 1);

    // long run of ones saturates run_len
    do_reset("r4");
    for (int k = 1; k <= 20; k++)
      step("run", 1, 1, (k == 1) ? 1 : 0, 0, 0, 0, (k > 15) ? 15 : k);
    step("run_end", 1, 0, 0, 1, 0, 0, 0);

    // enable gaps hold state and do not create edges
    do_reset("r5");
    step("g1", 1, 1, 1, 0, 0, 0, 1);
    step("g2", 1, 1, 0, 0, 0, 0, 2);
    step("gap1", 0, 0, 0, 0, 0, 0, 2);
    step("gap2", 0, 1, 0, 0, 0, 0, 2);
    step("gap3", 0, 0, 0, 0, 0, 0, 2);
    step("g3", 1, 0, 0, 1, 0, 0, 0);
    step("g4", 1, 1, 1, 0, 1, 1, 1);

    // five hits: 2-bit counter wraps; then mid-pattern reset
    do_reset("r6");
    step("w1", 1, 1, 1, 0, 0, 0, 1);
    step("w2", 1, 1, 0, 0, 0, 0, 2);
    step("w3", 1, 0, 0, 1, 0, 0, 0);
    step("w4", 1, 1, 1, 0, 1, 1, 1);
    for (int i = 2; i <= 5; i++) begin
      step("wa", 1, 1, 0, 0, 0, i - 1, 2);
      step("wb", 1, 0, 0, 1, 0, i - 1, 0);
      step("wc", 1, 1, 1, 0, 1, i, 1);
    end
    step("m1", 1, 1, 0, 0, 0, 5, 2);
    step("m2", 1, 1, 0, 0, 0, 5, 3);
    do_reset("r7");
    step("n1", 1, 0, 0, 0, 0, 0, 0);
    step("n2", 1, 1, 1, 0, 0, 0, 1);
    step("n3", 1, 1, 0, 0, 0, 0, 2);
    step("n4", 1, 0, 0, 1, 0, 0, 0);
    step("n5", 1, 1, 1, 0, 1, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_monitor.md
SEQ_MONITOR -- requirements
Module: seq_monitor

Interface
REQ-001 Parameter: PATTERN, 4'b1101, 4-bit serial pattern to detect, oldest bit in PATTERN[3], newest in PATTERN[0].
REQ-002 Parameter: CNT_W, 8, width of detection counter hit_cnt.
REQ-003 Port: clk  input  1  single clock; all state changes on posedge clk.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: en  input  1  sample enable; q sampled only on posedge clk with en=1.
REQ-006 Port: q  input  1  serial data bit from upstream dff q output.
REQ-007 Port: rise  output  1  one-cycle pulse: sampled bit went 0->1.
REQ-008 Port: fall  output  1  one-cycle pulse: sampled bit went 1->0.
REQ-009 Port: hit  output  1  one-cycle pulse: last 4 samples equal PATTERN.
REQ-010 Port: hit_cnt  output  CNT_W  running count of hit pulses.
REQ-011 Port: run_len  output  4  length of current run of consecutive 1 samples.
REQ-012 All outputs SHALL be registered; no combinational path from q or en to any output.

Function
REQ-013 Sample event: posedge clk with en=1; new sample s = q at that edge.
REQ-014 On sample event: history shifts left, s enters history[0]; prev register <= s.
REQ-015 Fill counter SHALL count samples 0..4 since reset, saturating at 4; states EMPTY(0), FILL(1..3), FULL(4).
REQ-016 rise SHALL be 1 for the cycle after a sample event with s=1 and prev=0; else 0.
REQ-017 fall SHALL be 1 for the cycle after a sample event with s=0 and prev=1; else 0.
REQ-018 hit SHALL be 1 for the cycle after a sample event where the 4 most recent samples (including s) equal PATTERN and fill reaches FULL on or before that event; else 0.
REQ-019 Detection SHALL be overlapping: history not cleared on hit; e.g. 1101101 yields two hits for PATTERN=1101.
REQ-020 Latency: rise/fall/hit assert exactly one clk after the sampling edge, duration exactly one clk per sample event.
REQ-021 hit_cnt SHALL increment by 1 on the same edge hit is set; wraps 2^CNT_W-1 -> 0, no saturation, no flag.
REQ-022 run_len SHALL become min(run_len+1,15) on sample s=1 and 0 on sample s=0; saturates at 15.
REQ-023 posedge clk with en=0: rise, fall, hit SHALL be 0; history, prev, fill, hit_cnt, run_len hold.
REQ-024 en toggling SHALL not create edges: rise/fall compare only consecutive sample events, regardless of gaps.
REQ-025 q changing between clock edges SHALL have no effect; only value at sampling edge counts.

Reset
REQ-026 rst_n=0 SHALL immediately, without clk, force: rise=0, fall=0, hit=0, hit_cnt=0, run_len=0, history=4'b0000, prev=0, fill=0 (EMPTY).
REQ-027 While rst_n=0 all state SHALL hold reset values regardless of clk, en, q.
REQ-028 First posedge after rst_n rises SHALL be treated as a normal edge; reset mid-stream discards partial pattern and history.
REQ-029 First sample after reset with s=1 SHALL pulse rise (prev reset value 0); with s=0 no fall.

Verification
REQ-030 Reset, en=1, q=1,1,0,1 on 4 edges -> rise after edges 1 and 4, fall after edge 3, hit after edge 4, hit_cnt=1, run_len=1.
REQ-031 en=1, q=1,1,0,1,1,0,1 -> hit after edges 4 and 7, hit_cnt=2 (overlap).
REQ-032 Reset, q=1,0,1 then q=1 (3 samples only before 4th) -> no hit until 4 samples; sequence 0,1,1,0,1 -> exactly one hit after edge 5.
REQ-033 en=1 q=1 for 20 edges -> run_len 1..15 then held at 15; single rise, no fall; q=0 next -> run_len=0, fall=1.
REQ-034 Samples 1,1 then en=0 for 3 edges with q toggling, then en=1 samples 0,1 -> no pulses during en=0, fall then hit on resumed samples, hit_cnt=1.
REQ-035 CNT_W=2, feed 5 pattern hits -> hit_cnt sequence 1,2,3,0,1; rst_n pulsed low between clk edges mid-pattern -> all outputs 0 immediately, next hit needs 4 new samples.
